// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU.
// One operation is in flight at a time: IDLE accepts, EXEC evaluates, RESP holds the result.
module alu_arbiter #(
    parameter bit FAIR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [31:0] req0_a_i,
    input  logic [31:0] req0_b_i,
    input  logic [4:0]  req0_op_i,
    input  logic [4:0]  req0_shamt_i,

    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [31:0] req1_a_i,
    input  logic [31:0] req1_b_i,
    input  logic [4:0]  req1_op_i,
    input  logic [4:0]  req1_shamt_i,

    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic [4:0]  alu_op_o,
    output logic [4:0]  alu_shamt_o,
    input  logic [31:0] alu_result_i,
    input  logic        alu_ne_i,
    input  logic        alu_lt_i,
    input  logic        alu_ovf_i,

    output logic        resp0_valid_o,
    input  logic        resp0_ready_i,
    output logic        resp1_valid_o,
    input  logic        resp1_ready_i,
    output logic [31:0] resp_result_o,
    output logic        resp_ne_o,
    output logic        resp_lt_o,
    output logic        resp_ovf_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q;
    logic        last_grant_q;
    logic        id_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [4:0]  op_q;
    logic [4:0]  shamt_q;
    logic [31:0] result_q;
    logic        ne_q;
    logic        lt_q;
    logic        ovf_q;
    logic        resp0_valid_q;
    logic        resp1_valid_q;

    logic        grant0;
    logic        grant1;
    logic        resp_hs;

    // On a tie, round-robin favours whoever did not win last; fixed mode always favours 0.
    assign grant0  = req0_valid_i && (!req1_valid_i || !FAIR || last_grant_q);
    assign grant1  = req1_valid_i && !grant0;
    assign resp_hs = id_q ? resp1_ready_i : resp0_ready_i;

    assign req0_ready_o  = (state_q == IDLE) && grant0;
    assign req1_ready_o  = (state_q == IDLE) && grant1;

    assign alu_a_o       = a_q;
    assign alu_b_o       = b_q;
    assign alu_op_o      = op_q;
    assign alu_shamt_o   = shamt_q;
    assign resp0_valid_o = resp0_valid_q;
    assign resp1_valid_o = resp1_valid_q;
    assign resp_result_o = result_q;
    assign resp_ne_o     = ne_q;
    assign resp_lt_o     = lt_q;
    assign resp_ovf_o    = ovf_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            id_q          <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= '0;
            shamt_q       <= '0;
            result_q      <= '0;
            ne_q          <= 1'b0;
            lt_q          <= 1'b0;
            ovf_q         <= 1'b0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant0 || grant1) begin
                        a_q          <= grant1 ? req1_a_i     : req0_a_i;
                        b_q          <= grant1 ? req1_b_i     : req0_b_i;
                        op_q         <= grant1 ? req1_op_i    : req0_op_i;
                        shamt_q      <= grant1 ? req1_shamt_i : req0_shamt_i;
                        id_q         <= grant1;
                        last_grant_q <= grant1;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    result_q      <= alu_result_i;
                    ne_q          <= alu_ne_i;
                    lt_q          <= alu_lt_i;
                    ovf_q         <= alu_ovf_i;
                    resp0_valid_q <= !id_q;
                    resp1_valid_q <= id_q;
                    state_q       <= RESP;
                end
                RESP: begin
                    // Only the owner's ready completes the handshake.
                    if (resp_hs) begin
                        resp0_valid_q <= 1'b0;
                        resp1_valid_q <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin and a fixed-priority instance share stimulus,
// each driving a behavioural ALU model from its own alu_* outputs.
module tb_alu_arbiter;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_SLL = 5'd2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req0_valid, req1_valid, resp0_ready, resp1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]  req0_op, req0_shamt, req1_op, req1_shamt;

    logic        f_req0_ready, f_req1_ready, f_resp0_valid, f_resp1_valid;
    logic [31:0] f_alu_a, f_alu_b, f_alu_result, f_resp_result;
    logic [4:0]  f_alu_op, f_alu_shamt;
    logic        f_alu_ne, f_alu_lt, f_alu_ovf, f_resp_ne, f_resp_lt, f_resp_ovf;

    logic        p_req0_ready, p_req1_ready, p_resp0_valid, p_resp1_valid;
    logic [31:0] p_alu_a, p_alu_b, p_alu_result, p_resp_result;
    logic [4:0]  p_alu_op, p_alu_shamt;
    logic        p_alu_ne, p_alu_lt, p_alu_ovf, p_resp_ne, p_resp_lt, p_resp_ovf;

    int checks = 0;
    int errors = 0;

    function automatic logic [34:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [4:0] sh);
        logic [31:0] r;
        logic        ovf;
        case (op)
            OP_SUB: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
            OP_SLL: begin r = a << sh; ovf = 1'b0; end
            default: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
        endcase
        return {ovf, ($signed(a) < $signed(b)), (a != b), r};
    endfunction

    assign {f_alu_ovf, f_alu_lt, f_alu_ne, f_alu_result} = alu_model(f_alu_op, f_alu_a, f_alu_b, f_alu_shamt);
    assign {p_alu_ovf, p_alu_lt, p_alu_ne, p_alu_result} = alu_model(p_alu_op, p_alu_a, p_alu_b, p_alu_shamt);

    alu_arbiter #(.FAIR(1'b1)) dut_fair (
        .clk(clk), .rst(rst),
        .req0_valid_i(req0_valid), .req0_ready_o(f_req0_ready), .req0_a_i(req0_a), .req0_b_i(req0_b),
        .req0_op_i(req0_op), .req0_shamt_i(req0_shamt),
        .req1_valid_i(req1_valid), .req1_ready_o(f_req1_ready), .req1_a_i(req1_a), .req1_b_i(req1_b),
        .req1_op_i(req1_op), .req1_shamt_i(req1_shamt),
        .alu_a_o(f_alu_a), .alu_b_o(f_alu_b), .alu_op_o(f_alu_op), .alu_shamt_o(f_alu_shamt),
        .alu_result_i(f_alu_result), .alu_ne_i(f_alu_ne), .alu_lt_i(f_alu_lt), .alu_ovf_i(f_alu_ovf),
        .resp0_valid_o(f_resp0_valid), .resp0_ready_i(resp0_ready),
        .resp1_valid_o(f_resp1_valid), .resp1_ready_i(resp1_ready),
        .resp_result_o(f_resp_result), .resp_ne_o(f_resp_ne), .resp_lt_o(f_resp_lt), .resp_ovf_o(f_resp_ovf)
    );

    alu_arbiter #(.FAIR(1'b0)) dut_prio (
        .clk(clk), .rst(rst),
        .req0_valid_i(req0_valid), .req0_ready_o(p_req0_ready), .req0_a_i(req0_a), .req0_b_i(req0_b),
        .req0_op_i(req0_op), .req0_shamt_i(req0_shamt),
        .req1_valid_i(req1_valid), .req1_ready_o(p_req1_ready), .req1_a_i(req1_a), .req1_b_i(req1_b),
        .req1_op_i(req1_op), .req1_shamt_i(req1_shamt),
        .alu_a_o(p_alu_a), .alu_b_o(p_alu_b), .alu_op_o(p_alu_op), .alu_shamt_o(p_alu_shamt),
        .alu_result_i(p_alu_result), .alu_ne_i(p_alu_ne), .alu_lt_i(p_alu_lt), .alu_ovf_i(p_alu_ovf),
        .resp0_valid_o(p_resp0_valid), .resp0_ready_i(resp0_ready),
        .resp1_valid_o(p_resp1_valid), .resp1_ready_i(resp1_ready),
        .resp_result_o(p_resp_result), .resp_ne_o(p_resp_ne), .resp_lt_o(p_resp_lt), .resp_ovf_o(p_resp_ovf)
    );

    // Each scenario starts and ends 1 time unit after a rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic drive_req(input bit id, input logic v, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] op, input logic [4:0] sh);
        if (id) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op; req1_shamt = sh;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op; req0_shamt = sh;
        end
    endtask

    // Full transaction on the round-robin instance; the operands are scrambled after acceptance.
    task automatic do_txn(input bit id, input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                          input logic [4:0] sh, output logic rdy, output logic vld, output logic [31:0] res,
                          output logic ne, output logic lt, output logic ovf);
        drive_req(id, 1'b1, a, b, op, sh);
        neg();
        rdy = id ? f_req1_ready : f_req0_ready;
        cyc();
        drive_req(id, 1'b0, 32'hffff_ffff, 32'h1234_5678, OP_ADD, 5'd31);
        neg();
        cyc();
        if (id) resp1_ready = 1'b1; else resp0_ready = 1'b1;
        neg();
        vld = id ? f_resp1_valid : f_resp0_valid;
        res = f_resp_result; ne = f_resp_ne; lt = f_resp_lt; ovf = f_resp_ovf;
        cyc();
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; resp0_ready = 1'b0; resp1_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0; req0_shamt = '0;
        req1_a = '0; req1_b = '0; req1_op = '0; req1_shamt = '0;
        repeat (2) @(posedge clk);
        neg();
        checks++; if (f_req0_ready !== 1'b0 || f_req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b%b expected 00", f_req0_ready, f_req1_ready); end
        checks++; if (f_resp0_valid !== 1'b0 || f_resp1_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b%b expected 00", f_resp0_valid, f_resp1_valid); end
        checks++; if (f_alu_a !== 32'h0 || f_alu_b !== 32'h0) begin errors++; $display("FAIL reset_alu_ab: got %h %h expected 0 0", f_alu_a, f_alu_b); end
        checks++; if (f_alu_op !== 5'h0 || f_alu_shamt !== 5'h0) begin errors++; $display("FAIL reset_alu_op: got %h %h expected 0 0", f_alu_op, f_alu_shamt); end
        checks++; if (f_resp_result !== 32'h0) begin errors++; $display("FAIL reset_resp_result: got %h expected 0", f_resp_result); end
        checks++; if ({f_resp_ne, f_resp_lt, f_resp_ovf} !== 3'b000) begin errors++; $display("FAIL reset_resp_flags: got %b expected 000", {f_resp_ne, f_resp_lt, f_resp_ovf}); end
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_single();
        drive_req(1'b0, 1'b1, 32'd5, 32'd5, OP_SUB, 5'd0);
        neg();
        checks++; if (f_req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready0: got %b expected 1", f_req0_ready); end
        checks++; if (f_req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready1: got %b expected 0", f_req1_ready); end
        cyc();
        drive_req(1'b0, 1'b0, 32'hdead_beef, 32'h0000_0001, OP_ADD, 5'd3);
        neg();
        checks++; if (f_alu_a !== 32'd5 || f_alu_b !== 32'd5 || f_alu_op !== OP_SUB) begin errors++; $display("FAIL single_alu_latch: got %h %h %h expected 5 5 1", f_alu_a, f_alu_b, f_alu_op); end
        checks++; if (f_resp0_valid !== 1'b0) begin errors++; $display("FAIL single_exec_valid: got %b expected 0", f_resp0_valid); end
        cyc();
        resp0_ready = 1'b1;
        neg();
        checks++; if (f_resp0_valid !== 1'b1 || f_resp1_valid !== 1'b0) begin errors++; $display("FAIL single_resp_valid: got %b%b expected 10", f_resp0_valid, f_resp1_valid); end
        checks++; if (f_resp_result !== 32'h0) begin errors++; $display("FAIL single_result: got %h expected 0", f_resp_result); end
        checks++; if (f_resp_ne !== 1'b0 || f_resp_lt !== 1'b0) begin errors++; $display("FAIL single_flags: got ne=%b lt=%b expected 0 0", f_resp_ne, f_resp_lt); end
        cyc();
        resp0_ready = 1'b0;
        neg();
        checks++; if (f_resp0_valid !== 1'b0) begin errors++; $display("FAIL single_done: got %b expected 0", f_resp0_valid); end
        checks++; if (f_alu_a !== 32'd5) begin errors++; $display("FAIL single_alu_hold: got %h expected 5", f_alu_a); end
        cyc();
    endtask

    task automatic test_flags();
        logic rdy, vld, ne, lt, ovf;
        logic [31:0] res;
        do_txn(1'b0, 32'h8000_0000, 32'h1, OP_SUB, 5'd0, rdy, vld, res, ne, lt, ovf);
        checks++; if (rdy !== 1'b1 || vld !== 1'b1) begin errors++; $display("FAIL flags_ovf_hs: got rdy=%b vld=%b expected 1 1", rdy, vld); end
        checks++; if (res !== 32'h7fff_ffff) begin errors++; $display("FAIL flags_ovf_result: got %h expected 7fffffff", res); end
        checks++; if ({ovf, lt, ne} !== 3'b111) begin errors++; $display("FAIL flags_ovf_flags: got ovf/lt/ne=%b expected 111", {ovf, lt, ne}); end
        do_txn(1'b1, 32'd3, 32'd7, OP_SUB, 5'd0, rdy, vld, res, ne, lt, ovf);
        checks++; if (rdy !== 1'b1 || vld !== 1'b1) begin errors++; $display("FAIL flags_lt_hs: got rdy=%b vld=%b expected 1 1", rdy, vld); end
        checks++; if (res !== 32'hffff_fffc) begin errors++; $display("FAIL flags_lt_result: got %h expected fffffffc", res); end
        checks++; if ({ovf, lt, ne} !== 3'b011) begin errors++; $display("FAIL flags_lt_flags: got ovf/lt/ne=%b expected 011", {ovf, lt, ne}); end
        do_txn(1'b0, 32'h0000_00ff, 32'h0, OP_SLL, 5'd8, rdy, vld, res, ne, lt, ovf);
        checks++; if (res !== 32'h0000_ff00) begin errors++; $display("FAIL flags_shamt_result: got %h expected 0000ff00", res); end
    endtask

    task automatic test_tie();
        logic fg [4];
        logic pg [4];
        int   nf = 0;
        int   np = 0;
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        drive_req(1'b0, 1'b1, 32'd1, 32'd2, OP_ADD, 5'd0);
        drive_req(1'b1, 1'b1, 32'd10, 32'd20, OP_ADD, 5'd0);
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            neg();
            checks++; if (f_req0_ready && f_req1_ready) begin errors++; $display("FAIL tie_both_ready: cycle %0d got 11 expected at most one", c); end
            checks++; if (p_resp1_valid !== 1'b0) begin errors++; $display("FAIL tie_prio_resp1: cycle %0d got %b expected 0", c, p_resp1_valid); end
            if (f_req0_ready && nf < 4) begin fg[nf] = 1'b0; nf++; end
            if (f_req1_ready && nf < 4) begin fg[nf] = 1'b1; nf++; end
            if (p_req0_ready && np < 4) begin pg[np] = 1'b0; np++; end
            if (p_req1_ready && np < 4) begin pg[np] = 1'b1; np++; end
            if (f_resp0_valid) begin
                checks++; if (f_resp_result !== 32'd3) begin errors++; $display("FAIL tie_result0: got %h expected 3", f_resp_result); end
            end
            if (f_resp1_valid) begin
                checks++; if (f_resp_result !== 32'd30) begin errors++; $display("FAIL tie_result1: got %h expected 1e", f_resp_result); end
            end
            if (p_resp0_valid) begin
                checks++; if (p_resp_result !== 32'd3 || {p_resp_ne, p_resp_lt, p_resp_ovf} !== 3'b110) begin errors++; $display("FAIL tie_prio_resp: got %h %b expected 3 110", p_resp_result, {p_resp_ne, p_resp_lt, p_resp_ovf}); end
            end
            cyc();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checks++; if (nf !== 4 || np !== 4) begin errors++; $display("FAIL tie_grant_count: got %0d %0d expected 4 4", nf, np); end
        for (int i = 0; i < 4; i++) begin
            if (i < nf) begin
                checks++; if (fg[i] !== i[0]) begin errors++; $display("FAIL tie_fair_grant%0d: got %b expected %b", i, fg[i], i[0]); end
            end
            if (i < np) begin
                checks++; if (pg[i] !== 1'b0) begin errors++; $display("FAIL tie_prio_grant%0d: got %b expected 0", i, pg[i]); end
            end
        end
        neg();
        cyc();
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        drive_req(1'b1, 1'b1, 32'd9, 32'd4, OP_SUB, 5'd0);
        neg();
        checks++; if (f_req1_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b expected 1", f_req1_ready); end
        cyc();
        drive_req(1'b1, 1'b0, 32'd0, 32'd0, OP_ADD, 5'd0);
        drive_req(1'b0, 1'b1, 32'd2, 32'd2, OP_ADD, 5'd0);
        neg();
        checks++; if (f_req0_ready !== 1'b0) begin errors++; $display("FAIL bp_exec_ready0: got %b expected 0", f_req0_ready); end
        for (int i = 0; i < 4; i++) begin
            cyc();
            neg();
            checks++; if (f_resp1_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid%0d: got %b expected 1", i, f_resp1_valid); end
            checks++; if (f_resp_result !== 32'd5) begin errors++; $display("FAIL bp_hold_result%0d: got %h expected 5", i, f_resp_result); end
            checks++; if (f_resp_ne !== 1'b1 || f_resp_lt !== 1'b0) begin errors++; $display("FAIL bp_hold_flags%0d: got ne=%b lt=%b expected 1 0", i, f_resp_ne, f_resp_lt); end
            checks++; if (f_req0_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready0_%0d: got %b expected 0", i, f_req0_ready); end
        end
        cyc();
        resp1_ready = 1'b1;
        neg();
        checks++; if (f_resp1_valid !== 1'b1) begin errors++; $display("FAIL bp_before_hs: got %b expected 1", f_resp1_valid); end
        cyc();
        resp1_ready = 1'b0;
        neg();
        checks++; if (f_resp1_valid !== 1'b0 || f_req0_ready !== 1'b1) begin errors++; $display("FAIL bp_after_hs: got valid1=%b ready0=%b expected 0 1", f_resp1_valid, f_req0_ready); end
        cyc();
        drive_req(1'b0, 1'b0, 32'd0, 32'd0, OP_SUB, 5'd0);
        neg();
        cyc();
        resp0_ready = 1'b1;
        neg();
        checks++; if (f_resp0_valid !== 1'b1 || f_resp_result !== 32'd4) begin errors++; $display("FAIL bp_second_txn: got valid0=%b result=%h expected 1 4", f_resp0_valid, f_resp_result); end
        cyc();
        resp0_ready = 1'b0;
    endtask

    task automatic test_stray();
        drive_req(1'b0, 1'b1, 32'd10, 32'd3, OP_SUB, 5'd0);
        neg();
        cyc();
        req0_valid = 1'b0;
        neg();
        cyc();
        resp1_ready = 1'b1;
        neg();
        checks++; if (f_resp0_valid !== 1'b1) begin errors++; $display("FAIL stray_resp_entry: got %b expected 1", f_resp0_valid); end
        cyc();
        resp1_ready = 1'b0;
        neg();
        checks++; if (f_resp0_valid !== 1'b1 || f_resp1_valid !== 1'b0) begin errors++; $display("FAIL stray_ignored: got %b%b expected 10", f_resp0_valid, f_resp1_valid); end
        checks++; if (f_resp_result !== 32'd7) begin errors++; $display("FAIL stray_result: got %h expected 7", f_resp_result); end
        cyc();
        resp0_ready = 1'b1;
        neg();
        cyc();
        resp0_ready = 1'b0;
        neg();
        checks++; if (f_resp0_valid !== 1'b0) begin errors++; $display("FAIL stray_done: got %b expected 0", f_resp0_valid); end
        cyc();
    endtask

    task automatic test_reset_resp();
        drive_req(1'b0, 1'b1, 32'd6, 32'd1, OP_SUB, 5'd2);
        neg();
        cyc();
        req0_valid = 1'b0;
        neg();
        cyc();
        neg();
        checks++; if (f_resp0_valid !== 1'b1) begin errors++; $display("FAIL rr_in_resp: got %b expected 1", f_resp0_valid); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (f_resp0_valid !== 1'b0) begin errors++; $display("FAIL rr_async_valid: got %b expected 0", f_resp0_valid); end
        checks++; if (f_resp_result !== 32'h0 || {f_resp_ne, f_resp_lt, f_resp_ovf} !== 3'b000) begin errors++; $display("FAIL rr_async_resp: got %h %b expected 0 000", f_resp_result, {f_resp_ne, f_resp_lt, f_resp_ovf}); end
        checks++; if (f_alu_a !== 32'h0 || f_alu_b !== 32'h0 || f_alu_op !== 5'h0 || f_alu_shamt !== 5'h0) begin errors++; $display("FAIL rr_async_alu: got %h %h %h %h expected all 0", f_alu_a, f_alu_b, f_alu_op, f_alu_shamt); end
        cyc();
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            neg();
            checks++; if (f_resp0_valid !== 1'b0 || f_resp1_valid !== 1'b0) begin errors++; $display("FAIL rr_no_resp%0d: got %b%b expected 00", i, f_resp0_valid, f_resp1_valid); end
            cyc();
        end
        drive_req(1'b0, 1'b1, 32'd1, 32'd1, OP_ADD, 5'd0);
        drive_req(1'b1, 1'b1, 32'd1, 32'd1, OP_ADD, 5'd0);
        neg();
        checks++; if (f_req0_ready !== 1'b1 || f_req1_ready !== 1'b0) begin errors++; $display("FAIL rr_tie_after_reset: got %b%b expected 10", f_req0_ready, f_req1_ready); end
        cyc();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_flags();
        test_backpressure();
        test_stray();
        test_tie();
        test_reset_resp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: FAIR, default 1, meaning 1 = round-robin between requesters, 0 = fixed priority to requester 0.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 reqN_valid  input  1  requester N (N = 0,1) has an operation pending.
REQ-005 reqN_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-006 reqN_a, reqN_b  input  32 each  operands A and B of requester N.
REQ-007 reqN_op, reqN_shamt  input  5 each  ALU opcode and shift amount of requester N.
REQ-008 alu_a, alu_b  output  32 each  operands driven to the shared ALU.
REQ-009 alu_op, alu_shamt  output  5 each  opcode and shift amount driven to the shared ALU.
REQ-010 alu_result  input  32  combinational ALU data result.
REQ-011 alu_ne, alu_lt, alu_ovf  input  1 each  combinational ALU isNotEqual, isLessThan and overflow flags.
REQ-012 respN_valid  output  1  response for requester N is held on the shared response bus.
REQ-013 respN_ready  input  1  requester N consumes the response.
REQ-014 resp_result  output  32  captured ALU result, shared by both requesters.
REQ-015 resp_ne, resp_lt, resp_ovf  output  1 each  captured ALU flags.

Function
REQ-016 The FSM SHALL have three states: IDLE, EXEC and RESP; exactly one transaction SHALL be in flight at a time.
REQ-017 In IDLE, a grant SHALL go to the single valid requester; if both are valid, FAIR=1 grants the requester not granted last, and FAIR=0 grants requester 0.
REQ-018 reqN_ready SHALL equal (state==IDLE) AND grantN, combinationally; it SHALL never be high for both requesters, and SHALL be 0 in EXEC and RESP.
REQ-019 On acceptance (reqN_valid AND reqN_ready), the arbiter SHALL latch operands, opcode, shamt and grant ID into internal registers, update last_grant, and move to EXEC.
REQ-020 alu_a, alu_b, alu_op and alu_shamt SHALL be driven only from the latched registers, and SHALL hold their values outside EXEC.
REQ-021 At the end of EXEC, the arbiter SHALL capture alu_result, alu_ne, alu_lt and alu_ovf into the resp_* registers and move to RESP.
REQ-022 Latency SHALL be fixed: acceptance in cycle N, EXEC in cycle N+1, and respN_valid first high in cycle N+2.
REQ-023 In RESP, only the granted requester's respN_valid SHALL be high, and resp_* SHALL remain stable until respN_ready is sampled high.
REQ-024 When respN_valid AND respN_ready, the FSM SHALL return to IDLE; the next acceptance is possible no earlier than the following cycle, so throughput is at most one operation per 3 cycles.
REQ-025 A respN_ready from the non-granted requester SHALL be ignored.
REQ-026 Changes to reqN_valid or operand inputs after acceptance SHALL have no effect on the in-flight transaction.
REQ-027 Operands and results SHALL pass through unmodified at 32 bits, with no sign or width conversion; overflow is reported, not corrected.
REQ-028 If no requester is valid in IDLE, the FSM SHALL stay in IDLE with both ready outputs low.

Reset
REQ-029 Asserting reset SHALL asynchronously force state=IDLE, last_grant=1 (requester 0 wins the first tie), all latched operand registers, alu_* and resp_* outputs to 0, and both respN_valid to 0.
REQ-030 Reset asserted mid-transaction (EXEC or RESP) SHALL discard the transaction; no response is issued after reset deasserts.
REQ-031 The first acceptance SHALL be possible in the first rising edge after reset deasserts.

Verification
REQ-032 Single request: req0 a=5, b=5, op=SUB -> ready0 high in cycle N; resp0_valid in N+2 with resp_result=0, resp_ne=0, resp_lt=0.
REQ-033 Tie with FAIR=1: both valid continuously, resp_ready tied high -> grants alternate 0,1,0,1; with FAIR=0 -> requester 0 is granted every time.
REQ-034 Backpressure: resp1_ready held low 4 cycles after resp1_valid -> resp_result, resp_ne and resp_lt stay constant and req0_ready stays 0 until the handshake completes.
REQ-035 Flag capture: a=0x80000000, b=1, op=SUB -> resp_ovf=1, resp_lt=1, resp_ne=1; a=3, b=7, op=SUB -> resp_lt=1, resp_ne=1, resp_ovf=0.
REQ-036 Reset during RESP: pulse reset while resp0_valid=1 -> resp0_valid=0 immediately (asynchronous), all outputs 0, and the next tie is granted to requester 0.
REQ-037 Stray handshake: resp1_ready pulsed while requester 0 is granted in RESP -> no state change, and resp0_valid remains 1.
